// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backing one 64-bit SRAM window: single-beat writes, FIXED/INCR/WRAP read bursts.
// Independent write and read FSMs; ATOP requests are rejected with SLVERR.
module axi_mem_responder #(
  parameter int                        AxiIdWidth   = 4,
  parameter int                        AxiAddrWidth = 64,
  parameter logic [AxiAddrWidth-1:0]   MemBase      = 64'h8000_0000,
  parameter int                        MemBytes     = 65536
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [AxiIdWidth-1:0]   aw_id_i,
  input  logic [AxiAddrWidth-1:0] aw_addr_i,
  input  logic [5:0]              aw_atop_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic [63:0]             w_data_i,
  input  logic [7:0]              w_strb_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [AxiIdWidth-1:0]   b_id_o,
  output logic [1:0]              b_resp_o,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [1:0]              ar_burst_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [63:0]             r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o
);
  localparam int Words = MemBytes / 8;
  localparam int WordW = $clog2(Words);
  typedef logic [AxiAddrWidth-1:0] addr_t;

  // Unsigned offset compare also rejects addresses below the base (they wrap to huge offsets).
  function automatic logic in_win(addr_t a);
    addr_t off;
    off = a - MemBase;
    return off < addr_t'(MemBytes);
  endfunction

  function automatic logic [WordW-1:0] widx(addr_t a);
    addr_t off;
    off = (a - MemBase) >> 3;
    return off[WordW-1:0];
  endfunction

  logic [63:0] mem [Words];

  // ---------------- write path ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  w_state_e              w_state, w_state_n;
  logic [AxiIdWidth-1:0] aw_id_q;
  addr_t                 aw_addr_q;
  logic [5:0]            aw_atop_q;
  logic                  wr_en;

  always_comb begin
    w_state_n  = w_state;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    case (w_state)
      W_IDLE: begin aw_ready_o = 1'b1; if (aw_valid_i) w_state_n = W_DATA; end
      W_DATA: begin w_ready_o  = 1'b1; if (w_valid_i)  w_state_n = W_RESP; end
      W_RESP: begin b_valid_o  = 1'b1; if (b_ready_i)  w_state_n = W_IDLE; end
      default: w_state_n = W_IDLE;
    endcase
  end

  assign wr_en = w_ready_o && w_valid_i && in_win(aw_addr_q) && (aw_atop_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state   <= W_IDLE;
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      aw_atop_q <= '0;
      b_id_o    <= '0;
      b_resp_o  <= '0;
    end else begin
      w_state <= w_state_n;
      if (aw_valid_i && aw_ready_o) begin
        aw_id_q   <= aw_id_i;
        aw_addr_q <= aw_addr_i;
        aw_atop_q <= aw_atop_i;
      end
      if (w_valid_i && w_ready_o) begin
        b_id_o   <= aw_id_q;
        b_resp_o <= !in_win(aw_addr_q) ? 2'b11 : (aw_atop_q != '0) ? 2'b10 : 2'b00;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en)
      for (int k = 0; k < 8; k++)
        if (w_strb_i[k]) mem[widx(aw_addr_q)][8*k +: 8] <= w_data_i[8*k +: 8];
  end

  // ---------------- read path ----------------
  typedef enum logic {R_IDLE, R_BURST} r_state_e;
  r_state_e   r_state, r_state_n;
  addr_t      beat_addr_q, next_addr, sel_addr, wrap_mask;
  logic [7:0] len_q, cnt_q, sel_len, sel_cnt;
  logic [1:0] burst_q, sel_burst;
  logic       fetch_en, burst_err;

  assign wrap_mask = addr_t'({len_q, 3'b111});

  always_comb begin
    case (burst_q)
      2'b00:   next_addr = beat_addr_q;
      2'b10:   next_addr = (beat_addr_q & ~wrap_mask) | ((beat_addr_q + addr_t'(8)) & wrap_mask);
      default: next_addr = beat_addr_q + addr_t'(8);
    endcase
  end

  // One fetch port: the first beat comes straight from AR, later beats from the advanced address.
  always_comb begin
    r_state_n  = r_state;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    sel_addr   = ar_addr_i & ~addr_t'(7);
    sel_len    = ar_len_i;
    sel_burst  = ar_burst_i;
    sel_cnt    = 8'd0;
    fetch_en   = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        fetch_en   = ar_valid_i;
        if (ar_valid_i) r_state_n = R_BURST;
      end
      R_BURST: begin
        r_valid_o = 1'b1;
        sel_addr  = next_addr;
        sel_len   = len_q;
        sel_burst = burst_q;
        sel_cnt   = cnt_q + 8'd1;
        fetch_en  = r_ready_i && !r_last_o;
        if (r_ready_i && r_last_o) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  assign burst_err = (sel_burst == 2'b11) ||
                     ((sel_burst == 2'b10) && !(sel_len == 8'd1 || sel_len == 8'd3 ||
                                                sel_len == 8'd7 || sel_len == 8'd15));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= R_IDLE;
      beat_addr_q <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      burst_q     <= '0;
      r_id_o      <= '0;
      r_data_o    <= '0;
      r_resp_o    <= '0;
      r_last_o    <= 1'b0;
    end else begin
      r_state <= r_state_n;
      if (ar_valid_i && ar_ready_o) r_id_o <= ar_id_i;
      if (fetch_en) begin
        beat_addr_q <= sel_addr;
        len_q       <= sel_len;
        burst_q     <= sel_burst;
        cnt_q       <= sel_cnt;
        r_last_o    <= (sel_cnt == sel_len);
        if (!in_win(sel_addr)) begin
          r_resp_o <= 2'b11;
          r_data_o <= '0;
        end else if (burst_err) begin
          r_resp_o <= 2'b10;
          r_data_o <= '0;
        end else begin
          r_resp_o <= 2'b00;
          r_data_o <= mem[widx(sel_addr)];
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder against a transaction-level memory/burst model.
module tb_axi_mem_responder;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          BYTES = 65536;

  logic        clk = 1'b0, rst_i = 1'b1;
  logic        aw_valid_i = 0, aw_ready_o, w_valid_i = 0, w_ready_o, b_valid_o, b_ready_i = 0;
  logic [3:0]  aw_id_i = 0, b_id_o, ar_id_i = 0, r_id_o;
  logic [63:0] aw_addr_i = 0, ar_addr_i = 0, w_data_i = 0, r_data_o;
  logic [5:0]  aw_atop_i = 0;
  logic [7:0]  w_strb_i = 0, ar_len_i = 0;
  logic [1:0]  b_resp_o, ar_burst_i = 0, r_resp_o;
  logic        ar_valid_i = 0, ar_ready_o, r_valid_o, r_ready_i = 0, r_last_o;

  int checks = 0, failures = 0;
  logic [63:0] mdl [longint];

  always #5 clk = ~clk;

  axi_mem_responder #(.AxiIdWidth(4), .AxiAddrWidth(64), .MemBase(BASE), .MemBytes(BYTES)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .aw_atop_i(aw_atop_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o),
    .b_resp_o(b_resp_o), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_burst_i(ar_burst_i), .r_valid_o(r_valid_o),
    .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o),
    .r_last_o(r_last_o));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic in_range(logic [63:0] a);
    return a >= BASE && a < BASE + 64'(BYTES);
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input logic [5:0] atop, input int bstall);
    logic [1:0]  exp_resp;
    longint      key;
    logic [63:0] cur;
    int          n;
    exp_resp = !in_range(addr) ? 2'b11 : (atop != 0) ? 2'b10 : 2'b00;
    if (exp_resp == 2'b00) begin
      key = longint'((addr - BASE) >> 3);
      if (mdl.exists(key) || strb == 8'hFF) begin
        cur = mdl.exists(key) ? mdl[key] : 64'h0;
        for (int k = 0; k < 8; k++) if (strb[k]) cur[8*k +: 8] = data[8*k +: 8];
        mdl[key] = cur;
      end
    end
    aw_valid_i = 1; aw_id_i = id; aw_addr_i = addr; aw_atop_i = atop;
    w_valid_i = 1; w_data_i = data; w_strb_i = strb;
    n = 0;
    @(negedge clk);
    while (!aw_ready_o && n < 20) begin @(negedge clk); n++; end
    chk("aw_ready", aw_ready_o, 1);
    chk("w_before_aw", w_ready_o, 0);
    @(posedge clk); #1 aw_valid_i = 0;
    @(negedge clk); chk("w_ready", w_ready_o, 1);
    @(posedge clk); #1 w_valid_i = 0; b_ready_i = 0;
    for (int s = 0; s < bstall; s++) begin
      @(negedge clk);
      chk("b_stall_valid", b_valid_o, 1);
      chk("b_stall_id", b_id_o, id);
      chk("b_stall_resp", b_resp_o, exp_resp);
      chk("aw_ready_stall", aw_ready_o, 0);
      @(posedge clk); #1;
    end
    b_ready_i = 1;
    @(negedge clk);
    chk("b_valid", b_valid_o, 1);
    chk("b_id", b_id_o, id);
    chk("b_resp", b_resp_o, exp_resp);
    @(posedge clk); #1 b_ready_i = 0;
    @(negedge clk); chk("aw_ready_after_b", aw_ready_o, 1);
    @(posedge clk); #1;
  endtask

  // rnd_ready: randomly stall R; abort_beat >= 0 asserts reset while that beat is presented.
  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input int len,
                         input logic [1:0] burst, input bit rnd_ready, input int abort_beat);
    logic [63:0] ea [$];
    logic [1:0]  er [$];
    logic [63:0] al, a, sz, lower, sv_data;
    logic [1:0]  sv_resp;
    logic [3:0]  sv_id;
    logic        sv_last, stalled, wrap_ok;
    int          i, cyc, n;
    al = addr & ~64'h7;
    sz = 64'((len + 1) * 8);
    wrap_ok = (len == 1 || len == 3 || len == 7 || len == 15);
    for (int b = 0; b <= len; b++) begin
      if (burst == 2'b00) a = al;
      else if (burst == 2'b10 && wrap_ok) begin
        lower = al - (al % sz);
        a = lower + ((al - lower + 64'(8 * b)) % sz);
      end else a = al + 64'(8 * b);
      ea.push_back(a);
      if (!in_range(a)) er.push_back(2'b11);
      else if (burst == 2'b11 || (burst == 2'b10 && !wrap_ok)) er.push_back(2'b10);
      else er.push_back(2'b00);
    end
    ar_valid_i = 1; ar_id_i = id; ar_addr_i = addr; ar_len_i = 8'(len); ar_burst_i = burst;
    n = 0;
    @(negedge clk);
    while (!ar_ready_o && n < 20) begin @(negedge clk); n++; end
    chk("ar_ready", ar_ready_o, 1);
    @(posedge clk); #1 ar_valid_i = 0;
    i = 0; cyc = 0; stalled = 0;
    sv_data = 0; sv_resp = 0; sv_id = 0; sv_last = 0;
    while (i <= len && cyc < 300) begin
      r_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (i == abort_beat) begin
        rst_i = 1;
        #1;
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_r_data", r_data_o, 0);
        chk("rst_r_last", r_last_o, 0);
        @(posedge clk); #1 rst_i = 0; r_ready_i = 0;
        @(negedge clk);
        chk("rst_ar_ready", ar_ready_o, 1);
        chk("rst_aw_ready", aw_ready_o, 1);
        chk("rst_r_valid_after", r_valid_o, 0);
        @(posedge clk); #1;
        return;
      end
      chk("r_valid", r_valid_o, 1);
      if (stalled) begin
        chk("r_stable_id", r_id_o, sv_id);
        chk("r_stable_data", r_data_o, sv_data);
        chk("r_stable_resp", r_resp_o, sv_resp);
        chk("r_stable_last", r_last_o, sv_last);
      end
      if (r_valid_o && r_ready_i) begin
        chk("r_id", r_id_o, id);
        chk("r_resp", r_resp_o, er[i]);
        chk("r_last", r_last_o, (i == len));
        if (er[i] == 2'b11) chk("r_data_decerr", r_data_o, 0);
        else if (er[i] == 2'b00 && mdl.exists(longint'((ea[i] - BASE) >> 3)))
          chk("r_data", r_data_o, mdl[longint'((ea[i] - BASE) >> 3)]);
        i++;
        stalled = 0;
      end else if (r_valid_o) begin
        stalled = 1;
        sv_id = r_id_o; sv_data = r_data_o; sv_resp = r_resp_o; sv_last = r_last_o;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (i <= len) chk("r_timeout_beats", 64'(i), 64'(len + 1));
    r_ready_i = 0;
    @(negedge clk); chk("r_valid_end", r_valid_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [1:0]  bu;
    int          len;
    repeat (2) @(negedge clk);
    chk("rst_aw_ready", aw_ready_o, 1);
    chk("rst_ar_ready", ar_ready_o, 1);
    chk("rst_w_ready", w_ready_o, 0);
    chk("rst_b_valid", b_valid_o, 0);
    chk("rst_r_valid", r_valid_o, 0);
    chk("rst_b_id_resp", {b_id_o, b_resp_o}, 0);
    chk("rst_r_outs", {r_id_o, r_resp_o, r_last_o}, 0);
    chk("rst_r_data", r_data_o, 0);
    @(posedge clk); #1 rst_i = 0;
    @(posedge clk); #1;

    for (int w = 0; w < 32; w++) do_write(4'(w), BASE + 64'(8 * w), {$urandom, $urandom}, 8'hFF, 0, 0);
    for (int w = 1; w <= 4; w++) do_write(4'(w), BASE + 64'(BYTES) - 64'(8 * w), {$urandom, $urandom}, 8'hFF, 0, 0);

    do_write(4'd3, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 0);
    do_read(4'd5, 64'h8000_0010, 0, 2'b01, 0, -1);
    do_write(4'd1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0);
    do_read(4'd2, 64'h8000_0010, 0, 2'b01, 0, -1);
    do_read(4'd6, 64'h8000_0018, 1, 2'b10, 0, -1);
    do_read(4'd7, BASE + 64'(BYTES) - 64'd16, 3, 2'b01, 0, -1);
    do_write(4'd4, 64'h0000_1000, {$urandom, $urandom}, 8'hFF, 0, 0);
    do_write(4'd9, 64'h8000_0010, {$urandom, $urandom}, 8'hFF, 6'h20, 0);
    do_read(4'd8, 64'h8000_0010, 0, 2'b01, 0, -1);
    do_write(4'd10, BASE + 64'h40, {$urandom, $urandom}, 8'hFF, 0, 5);
    do_read(4'd11, BASE + 64'h40, 7, 2'b01, 1, -1);
    do_read(4'd12, BASE + 64'h20, 7, 2'b01, 0, 2);
    do_read(4'd13, BASE + 64'h20, 7, 2'b01, 0, -1);
    do_read(4'd14, BASE + 64'h28, 3, 2'b11, 0, -1);
    do_read(4'd15, BASE + 64'h28, 2, 2'b10, 0, -1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = BASE + 64'(8 * $urandom_range(0, 31)) + 64'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) a = 64'h1000 + 64'($urandom_range(0, 255));
        do_write(4'($urandom), a, {$urandom, $urandom}, 8'($urandom),
                 ($urandom_range(0, 5) == 0) ? 6'($urandom_range(1, 63)) : 6'h0,
                 $urandom_range(0, 3));
      end else begin
        bu  = 2'($urandom_range(0, 3));
        len = (bu == 2'b10) ? (($urandom_range(0, 3) == 0) ? 2 : (($urandom_range(0, 1) == 0) ? 1 : 3))
                            : $urandom_range(0, 3);
        a = BASE + 64'(8 * $urandom_range(0, 27)) + 64'($urandom_range(0, 7));
        do_read(4'($urandom), a, len, bu, 1'($urandom_range(0, 1)), -1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder
Overview: Single-port AXI4 memory responder (subordinate) that is the far end of the core's AXI4 NoC master port. It backs one 64-bit SRAM window at MemBase and serves single-beat writes (the core issues no write bursts) and INCR/WRAP/FIXED read bursts, such as I$ line refills of 2 beats × 64 bits. It is used as scratchpad/boot memory in SoC and testbench tops. Atomics (ATOP) are not executed; they are rejected.
Parameters:
AxiIdWidth, 4, width of AW/AR/B/R ID fields.
AxiAddrWidth, 64, address width; data width is fixed at 64 bits, strobe width at 8.
MemBase, 64'h8000_0000, byte base address of the window; must be aligned to MemBytes.
MemBytes, 65536, window size in bytes; must be a power of two and ≥16; word index width is $clog2(MemBytes/8).
Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
aw_valid_i  in  1  write address valid
aw_ready_o  out  1  write address ready
aw_id_i  in  AxiIdWidth  write ID
aw_addr_i  in  AxiAddrWidth  write byte address
aw_atop_i  in  6  atomic opcode; nonzero is unsupported
w_valid_i  in  1  write data valid; every beat is a last beat
w_ready_o  out  1  write data ready
w_data_i  in  64  write data
w_strb_i  in  8  byte strobes
b_valid_o  out  1  write response valid
b_ready_i  in  1  write response ready
b_id_o  out  AxiIdWidth  echoed aw_id_i
b_resp_o  out  2  OKAY=00, SLVERR=10, DECERR=11
ar_valid_i  in  1  read address valid
ar_ready_o  out  1  read address ready
ar_id_i  in  AxiIdWidth  read ID
ar_addr_i  in  AxiAddrWidth  read byte address
ar_len_i  in  8  beats minus 1
ar_burst_i  in  2  FIXED=00, INCR=01, WRAP=10
r_valid_o  out  1  read data valid
r_ready_i  in  1  read data ready
r_id_o  out  AxiIdWidth  echoed ar_id_i
r_data_o  out  64  read data, full aligned word
r_resp_o  out  2  per-beat response
r_last_o  out  1  final beat of the burst
Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction): write FSM and read FSM go to IDLE. aw_ready_o=1, ar_ready_o=1, w_ready_o=0, b_valid_o=0, r_valid_o=0, and all ID/data/resp/last outputs=0. Any in-flight transaction is dropped. SRAM contents are not reset.
- Write FSM states: W_IDLE→W_DATA→W_RESP→W_IDLE.
  - W_IDLE: aw_ready_o=1. On AW handshake, latch id, addr and atop, and go to W_DATA.
  - W_DATA: w_ready_o=1. On W handshake, commit the write if in range and atop==0, then go to W_RESP.
  - W before AW: w_ready_o stays 0, so the W beat waits for its AW.
- Write commit: word index = (addr-MemBase)>>3, addr[2:0] ignored. Only bytes with w_strb_i[k]=1 are updated.
- Write response codes: address outside [MemBase, MemBase+MemBytes) gives DECERR with no write. atop≠0 gives SLVERR with no write. DECERR has priority over SLVERR.
- W_RESP: b_valid_o is held with stable b_id_o/b_resp_o until b_ready_i, then W_IDLE. aw_ready_o reasserts the cycle after the B handshake, so the minimum write throughput is one write every 3 cycles.
- Read FSM states: R_IDLE→R_BURST→R_IDLE.
  - R_IDLE: ar_ready_o=1. On AR handshake, latch id, addr, len and burst, read the first word into the output register, and go to R_BURST. r_valid_o rises the next cycle (1-cycle latency).
  - R_BURST: r_valid_o=1, and r_id_o/r_data_o/r_resp_o/r_last_o are held stable until r_ready_i.
  - On an R handshake that is not the last beat: advance the beat address, beat counter +1, and register the next word. Sustained throughput is one beat/cycle while r_ready_i=1.
  - On the last-beat handshake: go to R_IDLE; r_valid_o=0 the next cycle.
- Beat address, with word-aligned steps of 8:
  - FIXED: unchanged.
  - INCR: +8; may cross the window end, and those beats get DECERR.
  - WRAP: +8 wrapping inside a (len+1)*8-byte aligned block. len must be 1, 3, 7 or 15; any other len gives SLVERR on all beats.
  - ar_burst_i=11 (reserved) gives SLVERR on all beats.
- Read response codes: r_last_o=1 exactly when beat counter==len. An out-of-range beat returns DECERR with r_data_o=0. An error beat still counts toward len.
- Read and write FSMs are independent. If a write commit and a read word fetch hit the same word in the same cycle, the read returns the pre-write data.
Test Plan:
- AW id=3, addr=0x8000_0010 + W data=0x1122_3344_5566_7788, strb=0xFF; then AR addr=0x8000_0010, len=0, INCR -> B id=3 OKAY; R data=0x1122334455667788, OKAY, last=1, r_valid 1 cycle after AR handshake.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF with strb=0x0F over stored 0x1122334455667788 -> readback 0x11223344FFFFFFFF.
- WRAP len=1 at 0x8000_0018 with r_ready tied 1 -> beats from 0x...18 then 0x...10 on consecutive cycles, last on beat 2; INCR len=3 at MemBase+MemBytes-16 -> beats 1-2 OKAY, beats 3-4 DECERR with data 0, last on beat 4.
- Write to 0x0000_1000 -> B DECERR, memory unchanged; write with aw_atop=6'h20 in range -> B SLVERR, memory unchanged.
- Backpressure: hold b_ready_i=0 for 5 cycles, then toggle r_ready_i randomly during a len=7 INCR burst -> B and R outputs stable while stalled, aw_ready_o=0 until the B handshake, exactly 8 beats delivered in order.
- Assert rst_i mid-burst (beat 3 of 8) -> r_valid_o=0 in the same cycle, ar_ready_o=1 after release, and previously written data still readable.
